// File: rtl/apb_init_pkg.sv
// Shared types and constants for the APB3 command initiator.
// State encoding, PPROT bit positions and the default ACCESS timeout.
package apb_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/apb_init_timeout_cnt.sv
// ACCESS-phase wait counter: clears on entry to ACCESS, counts wait cycles,
// saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module apb_init_timeout_cnt
  import apb_init_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/apb_cmd_initiator.sv
// APB3 requester: one valid/ready command at a time -> one APB transfer -> one
// buffered response. Optional ACCESS timeout when APB_INIT_TIMEOUT_EN is defined.
module apb_cmd_initiator
  import apb_init_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-3:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-3:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic [2:0]        PPROT,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  state_e state;

`ifdef APB_INIT_TIMEOUT_EN
  logic expire;
  logic timeout_q;

  apb_init_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clear (state == ST_SETUP),
    .enable((state == ST_ACCESS) && !PREADY),
    .expire(expire)
  );

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: all state and outputs are registered with non-blocking assignments;
  // the async reset clears PSEL/PENABLE immediately, abandoning any transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PPROT     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_INIT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready is always high here, so req_valid alone is the handshake.
          if (req_valid) begin
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PPROT     <= req_prot;
            req_ready <= 1'b0;
            PSEL      <= 1'b1;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : 32'h0;
`ifdef APB_INIT_TIMEOUT_EN
            timeout_q <= 1'b0;
          end else if (expire) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            timeout_q <= 1'b1;
            state     <= ST_RESP;
`endif
          end
          if (PREADY) state <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Self-checking bench for apb_cmd_initiator: the bench acts as the APB completer
// with random wait states/errors and predicts each response from the command.
module tb_apb_cmd_initiator;

  localparam int ADDR_W = 12;
  localparam int TO_CYC = 8;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_initiator #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full command. Expected response comes from the command and the
  // completer behaviour chosen here, not from the DUT.
  task automatic run_cmd(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [2:0] prot, input int waits, input bit err,
                         input logic [31:0] rdata, input int bp, input bit expect_to);
    int  acc;
    bit  done;
    int  exp_acc;
    bit  exp_err;
    logic [31:0] exp_rdata;

    exp_acc   = expect_to ? TO_CYC : waits + 1;
    exp_err   = expect_to ? 1'b1 : err;
    exp_rdata = (!wr && !err && !expect_to) ? rdata : 32'h0;

    @(negedge PCLK);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_prot = prot;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0; req_write = $urandom; req_addr = 10'($urandom);
    req_wdata = $urandom; req_prot = 3'($urandom);
    check("setup_psel",    {31'b0, PSEL},    32'd1);
    check("setup_penable", {31'b0, PENABLE}, 32'd0);
    check("setup_req_rdy", {31'b0, req_ready}, 32'd0);
    PREADY = 1'b0; PSLVERR = $urandom; PRDATA = $urandom;

    acc = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        acc++;
        check("acc_paddr",  {22'b0, PADDR},  {22'b0, addr});
        check("acc_pwrite", {31'b0, PWRITE}, {31'b0, wr});
        check("acc_pwdata", PWDATA, wdata);
        check("acc_pprot",  {29'b0, PPROT},  {29'b0, prot});
        if (!expect_to && acc == waits + 1) begin
          PREADY = 1'b1; PSLVERR = err; PRDATA = rdata;
        end else begin
          PREADY = 1'b0; PSLVERR = $urandom; PRDATA = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check("access_bound", 32'd0, 32'd1);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

    check("access_cycles", 32'(acc), 32'(exp_acc));
    for (int j = 0; j <= bp; j++) begin
      if (j > 0) begin
        @(posedge PCLK);
        @(negedge PCLK);
      end
      check("rsp_valid",   {31'b0, rsp_valid},   32'd1);
      check("rsp_rdata",   rsp_rdata, exp_rdata);
      check("rsp_err",     {31'b0, rsp_err},     {31'b0, exp_err});
      check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, expect_to});
      check("resp_psel",   {31'b0, PSEL},        32'd0);
      check("resp_req_rdy",{31'b0, req_ready},   32'd0);
      check("resp_paddr",  {22'b0, PADDR},       {22'b0, addr});
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_prot = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_psel",      {31'b0, PSEL},      32'd0);
    check("rst_penable",   {31'b0, PENABLE},   32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_paddr",     {22'b0, PADDR},     32'd0);
    check("rst_pwdata",    PWDATA,             32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Directed cases.
    run_cmd(1'b1, 10'h002, 32'hDEADBEEF, 3'b001, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
    run_cmd(1'b0, 10'h155, 32'h0, 3'b000, 3, 1'b0, 32'h0000_00A5, 0, 1'b0);
    run_cmd(1'b0, 10'h3FF, 32'h0, 3'b010, 1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_cmd(1'b0, 10'h010, 32'h0, 3'b100, 0, 1'b0, 32'hCAFE_F00D, 5, 1'b0);
    run_cmd(1'b1, 10'h000, 32'h0BAD_0BAD, 3'b111, 2, 1'b1, 32'h5555_AAAA, 5, 1'b0);
`ifdef APB_INIT_TIMEOUT_EN
    run_cmd(1'b0, 10'h0AA, 32'h0, 3'b001, 0, 1'b0, 32'h0, 2, 1'b1);
    run_cmd(1'b0, 10'h0AB, 32'h0, 3'b001, TO_CYC - 1, 1'b0, 32'h7777_0001, 0, 1'b0);
`endif

    // Randomized commands.
    for (int n = 0; n < 30; n++) begin
      run_cmd(1'($urandom), 10'($urandom), $urandom, 3'($urandom),
              int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
              $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    // Async reset in the middle of ACCESS.
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h123; req_prot = 3'b001;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0; PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_penable", {31'b0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("arst_psel",      {31'b0, PSEL},      32'd0);
    check("arst_penable",   {31'b0, PENABLE},   32'd0);
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("post_arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("post_arst_psel",      {31'b0, PSEL},      32'd0);
      check("post_arst_req_ready", {31'b0, req_ready}, 32'd1);
    end
    rsp_ready = 1'b0;
    run_cmd(1'b0, 10'h321, 32'h0, 3'b011, 1, 1'b0, 32'h0000_BEEF, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
